dram_write_packer: RTL and testbench
====================================

Name: dram_write_packer

Overview:
- Sits directly upstream of the AXI DRAM writer.
- Accepts a narrow pixel/token stream plus a (start address, payload byte count) command, packs tokens little-endian into 64-bit words, and forwards a write command to the writer with the byte count rounded up to a whole 128-byte burst.
- Zero-pads the tail so the writer always receives exactly 16 beats per burst.

Parameters:
- IN_W, 16, input token width in bits; legal values 8, 16, 32, 64.
- LANES, 64/IN_W, derived tokens per output word; not to be overridden.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous active-high reset
- CFG_VALID  in  1  command valid
- CFG_READY  out  1  command ready; high only in IDLE
- CFG_START_ADDR  in  32  DRAM byte address; 128-byte aligned
- CFG_NBYTES  in  32  payload bytes
- WR_CONFIG_VALID  out  1  command to writer, valid
- WR_CONFIG_READY  in  1  writer command ready
- WR_CONFIG_START_ADDR  out  32  latched CFG_START_ADDR
- WR_CONFIG_NBYTES  out  32  payload rounded up to a multiple of 128
- IN_DATA  in  IN_W  token
- IN_VALID  in  1  token valid
- IN_READY  out  1  token ready
- OUT_DATA  out  64  packed word, to writer DATA
- OUT_VALID  out  1  to writer DATA_VALID
- OUT_READY  in  1  from writer DATA_READY
- BUSY  out  1  state != IDLE
- DONE  out  1  one-cycle pulse on final beat handshake, or for an empty command

Behaviour:
- Reset values (ARESET sampled high on an ACLK edge): state IDLE, WR_CONFIG_VALID=0, OUT_VALID=0, OUT_DATA=0, DONE=0, BUSY=0, all counters and the pack register cleared.
- Reset mid-operation:
  - Any partial word or pending beat is discarded.
  - No DONE pulse is issued.
  - The writer is reset by the same system reset.
- Derived values on CFG handshake (CFG_VALID && CFG_READY):
  - tok_rem = ceil(CFG_NBYTES / (IN_W/8)).
  - rnd = {CFG_NBYTES[31:7] + (|CFG_NBYTES[6:0]), 7'b0}, computed in 32 bits.
  - beat_rem = rnd >> 3.
  - CFG_NBYTES > 0xFFFFFF80 is illegal; behaviour is undefined.
- State machine:
  - IDLE:
    - CFG_READY=1.
    - On handshake with CFG_NBYTES==0: stay IDLE, DONE=1 next cycle, no writer command is issued. The writer must never see NBYTES=0 because its burst counter would wrap.
    - On handshake otherwise: latch address and rnd, go to CMD.
  - CMD:
    - WR_CONFIG_VALID=1; address and NBYTES are held stable.
    - On WR_CONFIG_READY go to PACK. WR_CONFIG_VALID drops the following cycle.
    - IN_READY=0 throughout CMD.
  - PACK:
    - IN_READY = (tok_rem!=0) && (!OUT_VALID || OUT_READY).
    - An accepted token goes to lane index lane (bits [lane*IN_W +: IN_W]). The first token lands in bits [IN_W-1:0].
    - lane increments, and tok_rem decrements.
    - When the token fills lane LANES-1, or is the last token (tok_rem==1), the word is loaded into OUT_DATA with unfilled lanes zero. OUT_VALID=1 next cycle, lane resets to 0, and the pack register clears.
    - When tok_rem reaches 0 and the final word is loaded, go to PAD.
  - PAD:
    - After each output handshake, if beat_rem is still nonzero, load OUT_DATA=0 with OUT_VALID=1.
    - No input is accepted in PAD.
- Output handshake (OUT_VALID && OUT_READY):
  - beat_rem decrements.
  - OUT_VALID and OUT_DATA stay stable while OUT_READY=0.
  - A new word may be loaded in the same cycle as a handshake, giving back-to-back beats. This gives full throughput when IN_W=64.
- Completion: the handshake that takes beat_rem from 1 to 0 gives DONE=1 on the next cycle, OUT_VALID=0, and state IDLE.
- Latency:
  - CFG handshake at cycle t gives WR_CONFIG_VALID at t+1.
  - The token completing a word, accepted at t, gives OUT_VALID at t+1.
- Simultaneous events: when the final token is accepted while the previous beat handshakes, the new word replaces it in that cycle and no bubble is inserted.

Test Plan:
- IN_W=16, CFG addr 0x1000, NBYTES=128, tokens 0..63 streamed continuously, OUT_READY=1 -> WR_CONFIG 0x1000/128 once, then 16 beats; beat0=0x0003000200010000 and beat15=0x003F003E003D003C; DONE one cycle after the 16th handshake; no padding beats.
- NBYTES=6, tokens 0xAAAA,0xBBBB,0xCCCC -> WR_CONFIG_NBYTES=128; beat0=0x0000CCCCBBBBAAAA followed by 15 zero beats; IN_READY=0 after the 3rd token; DONE after beat 16.
- NBYTES=0 -> WR_CONFIG_VALID never asserts; DONE pulses on the cycle after the handshake; CFG_READY stays 1; BUSY stays 0.
- NBYTES=256 with OUT_READY forced low for 10 cycles mid-stream -> OUT_DATA held constant, IN_READY=0 while stalled, exactly 32 beats, no token lost or duplicated (scoreboard).
- WR_CONFIG_READY held low for 5 cycles -> WR_CONFIG_VALID held with stable fields, IN_READY=0 and OUT_VALID=0 until the handshake; tokens start the cycle after.
- ARESET pulsed after 20 tokens of an NBYTES=128 command -> next cycle OUT_VALID=0, WR_CONFIG_VALID=0, BUSY=0, no DONE; a fresh NBYTES=128 command then completes with 16 correct beats.

Source files
------------

// File: rtl/dram_write_packer.sv
// Packs a narrow little-endian token stream into 64-bit words and issues one
// writer command per transfer, zero-padding the tail to a whole 128-byte burst.
module dram_write_packer #(
  parameter int IN_W = 16
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic            CFG_VALID,
  output logic            CFG_READY,
  input  logic [31:0]     CFG_START_ADDR,
  input  logic [31:0]     CFG_NBYTES,
  output logic            WR_CONFIG_VALID,
  input  logic            WR_CONFIG_READY,
  output logic [31:0]     WR_CONFIG_START_ADDR,
  output logic [31:0]     WR_CONFIG_NBYTES,
  input  logic [IN_W-1:0] IN_DATA,
  input  logic            IN_VALID,
  output logic            IN_READY,
  output logic [63:0]     OUT_DATA,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic            BUSY,
  output logic            DONE,
  output logic [1:0]      DBG_STATE
);

  // All ports use valid/ready: a transfer happens on a rising ACLK edge where
  // both are high; a source holds valid and payload stable until it transfers.

  localparam int LANES  = 64 / IN_W;
  localparam int BPT    = IN_W / 8;
  localparam int SH     = $clog2(BPT);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_PACK, S_PAD} state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       nbytes_q, nbytes_d;
  logic [31:0]       tok_rem_q, tok_rem_d;
  logic [31:0]       beat_rem_q, beat_rem_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [63:0]       pack_q, pack_d;
  logic [63:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              wr_valid_q, wr_valid_d;
  logic              done_q, done_d;

  logic        out_hs, in_hs, last_tok, word_full;
  logic [32:0] tok_sum;
  logic [31:0] rnd, beat_dec;
  logic [63:0] token_ext, merged;

  assign CFG_READY            = (state_q == S_IDLE);
  assign IN_READY             = (state_q == S_PACK) && (tok_rem_q != 32'd0) &&
                                (!out_valid_q || OUT_READY);
  assign WR_CONFIG_VALID      = wr_valid_q;
  assign WR_CONFIG_START_ADDR = addr_q;
  assign WR_CONFIG_NBYTES     = nbytes_q;
  assign OUT_DATA             = out_data_q;
  assign OUT_VALID            = out_valid_q;
  assign BUSY                 = (state_q != S_IDLE);
  assign DONE                 = done_q;
  assign DBG_STATE            = state_q;

  always_comb begin
    tok_sum   = {1'b0, CFG_NBYTES} + 33'(BPT - 1);
    rnd       = {CFG_NBYTES[31:7] + 25'(|CFG_NBYTES[6:0]), 7'b0};
    token_ext = 64'(IN_DATA);
    merged    = pack_q | (token_ext << (32'(lane_q) * IN_W));
    word_full = (lane_q == LANE_W'(LANES - 1));
    last_tok  = (tok_rem_q == 32'd1);
    out_hs    = out_valid_q && OUT_READY;
    in_hs     = IN_VALID && IN_READY;
    beat_dec  = beat_rem_q - 32'd1;

    state_d     = state_q;
    addr_d      = addr_q;
    nbytes_d    = nbytes_q;
    tok_rem_d   = tok_rem_q;
    beat_rem_d  = beat_rem_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    wr_valid_d  = wr_valid_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (CFG_VALID) begin
          // An empty command never reaches the writer: its burst count would wrap.
          if (CFG_NBYTES == 32'd0) begin
            done_d = 1'b1;
          end else begin
            addr_d     = CFG_START_ADDR;
            nbytes_d   = rnd;
            tok_rem_d  = 32'(tok_sum >> SH);
            beat_rem_d = rnd >> 3;
            lane_d     = '0;
            pack_d     = '0;
            wr_valid_d = 1'b1;
            state_d    = S_CMD;
          end
        end
      end
      S_CMD: begin
        if (WR_CONFIG_READY) begin
          wr_valid_d = 1'b0;
          state_d    = S_PACK;
        end
      end
      S_PACK: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          beat_rem_d  = beat_dec;
        end
        if (in_hs) begin
          tok_rem_d = tok_rem_q - 32'd1;
          if (word_full || last_tok) begin
            out_data_d  = merged;
            out_valid_d = 1'b1;
            lane_d      = '0;
            pack_d      = '0;
            if (last_tok) state_d = S_PAD;
          end else begin
            pack_d = merged;
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      S_PAD: begin
        if (out_hs) begin
          beat_rem_d = beat_dec;
          if (beat_dec != 32'd0) begin
            out_data_d  = '0;
            out_valid_d = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      nbytes_q    <= '0;
      tok_rem_q   <= '0;
      beat_rem_q  <= '0;
      lane_q      <= '0;
      pack_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      nbytes_q    <= nbytes_d;
      tok_rem_q   <= tok_rem_d;
      beat_rem_q  <= beat_rem_d;
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      wr_valid_q  <= wr_valid_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_dram_write_packer.sv
// Directed bench for dram_write_packer: a burst-level model of the expected
// beat stream plus a per-cycle compare process on the falling edge.
module tb_dram_write_packer;

  localparam int IN_W  = 16;
  localparam int LANES = 64 / IN_W;
  localparam int BPT   = IN_W / 8;

  logic            ACLK, ARESET;
  logic            CFG_VALID, CFG_READY;
  logic [31:0]     CFG_START_ADDR, CFG_NBYTES;
  logic            WR_CONFIG_VALID, WR_CONFIG_READY;
  logic [31:0]     WR_CONFIG_START_ADDR, WR_CONFIG_NBYTES;
  logic [IN_W-1:0] IN_DATA;
  logic            IN_VALID, IN_READY;
  logic [63:0]     OUT_DATA;
  logic            OUT_VALID, OUT_READY;
  logic            BUSY, DONE;
  logic [1:0]      DBG_STATE;

  dram_write_packer #(.IN_W(IN_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
    .CFG_START_ADDR(CFG_START_ADDR), .CFG_NBYTES(CFG_NBYTES),
    .WR_CONFIG_VALID(WR_CONFIG_VALID), .WR_CONFIG_READY(WR_CONFIG_READY),
    .WR_CONFIG_START_ADDR(WR_CONFIG_START_ADDR), .WR_CONFIG_NBYTES(WR_CONFIG_NBYTES),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .BUSY(BUSY), .DONE(DONE), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0]     exp_q[$];
  logic [63:0]     obs_q[$];
  logic [IN_W-1:0] tok_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beats: tokens packed little-endian, then zeros up to whole bursts.
  task automatic build_model(input int unsigned nbytes);
    int unsigned nbeats;
    logic [63:0] w;
    int k;
    nbeats = ((nbytes + 127) / 128) * 16;
    for (int b = 0; b < int'(nbeats); b++) begin
      w = '0;
      for (int l = 0; l < LANES; l++) begin
        k = b * LANES + l;
        if (k < tok_q.size()) w = w | (64'(tok_q[k]) << (l * IN_W));
      end
      exp_q.push_back(w);
    end
  endtask

  // compare process state
  logic        checking = 1'b0;
  logic        cmd_pend = 1'b0, active = 1'b0, done_exp = 1'b0;
  logic        stall_prev = 1'b0, first_tok_exp = 1'b0;
  logic [63:0] prev_data = '0, exp_w;
  logic [31:0] exp_addr = '0, exp_nb = '0, last_cmd_nbytes = '0;
  int          tok_left = 0, cmd_count = 0, done_count = 0;

  always @(negedge ACLK) begin
    if (checking) begin
      chk("done", DONE, done_exp);
      chk("wr_cfg_valid", WR_CONFIG_VALID, cmd_pend);
      chk("busy", BUSY, active);
      chk("cfg_ready", CFG_READY, !active);
      if (!active) chk("out_valid_idle", OUT_VALID, 0);
      if (stall_prev) begin
        chk("stall_valid", OUT_VALID, 1);
        chk("stall_data", OUT_DATA, prev_data);
      end
      if (WR_CONFIG_VALID) begin
        chk("wr_cfg_addr", WR_CONFIG_START_ADDR, exp_addr);
        chk("wr_cfg_nbytes", WR_CONFIG_NBYTES, exp_nb);
        chk("cmd_in_ready", IN_READY, 0);
        chk("cmd_out_valid", OUT_VALID, 0);
      end
      if (first_tok_exp) chk("first_tok_ready", IN_READY, 1);
      chk("in_ready_gate",
          IN_READY && !(tok_left > 0 && active && !cmd_pend && !(OUT_VALID && !OUT_READY)), 0);

      first_tok_exp = 1'b0;
      done_exp      = 1'b0;
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          exp_w = exp_q.pop_front();
          chk("beat_data", OUT_DATA, exp_w);
          if (exp_q.size() == 0) begin
            active   = 1'b0;
            done_exp = 1'b1;
          end
        end
        obs_q.push_back(OUT_DATA);
      end
      if (CFG_VALID && CFG_READY) begin
        if (CFG_NBYTES == 32'd0) begin
          done_exp = 1'b1;
        end else begin
          cmd_pend = 1'b1;
          active   = 1'b1;
          tok_left = int'((CFG_NBYTES + BPT - 1) / BPT);
          exp_addr = CFG_START_ADDR;
          exp_nb   = ((CFG_NBYTES + 127) / 128) * 128;
        end
      end
      if (WR_CONFIG_VALID && WR_CONFIG_READY) begin
        cmd_pend        = 1'b0;
        first_tok_exp   = 1'b1;
        cmd_count++;
        last_cmd_nbytes = WR_CONFIG_NBYTES;
      end
      if (IN_VALID && IN_READY) tok_left--;
      if (DONE) done_count++;
      stall_prev = OUT_VALID && !OUT_READY;
      prev_data  = OUT_DATA;
      if (ARESET) begin
        cmd_pend      = 1'b0;
        active        = 1'b0;
        done_exp      = 1'b0;
        stall_prev    = 1'b0;
        first_tok_exp = 1'b0;
        tok_left      = 0;
        exp_q.delete();
      end
    end
  end

  // driver tasks (all return 1 time unit after a rising edge)
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [31:0] nbytes);
    logic hs;
    int c;
    hs = 1'b0;
    c  = 0;
    CFG_VALID      = 1'b1;
    CFG_START_ADDR = addr;
    CFG_NBYTES     = nbytes;
    while (!hs && c < 50) begin
      @(negedge ACLK);
      hs = CFG_READY;
      tick();
      c++;
    end
    CFG_VALID = 1'b0;
    chk("cfg_timeout", !hs, 0);
  endtask

  task automatic feed(input int n);
    logic hs;
    int i, c;
    i = 0;
    c = 0;
    IN_VALID = 1'b1;
    IN_DATA  = tok_q[0];
    while (i < n && c < 2000) begin
      @(negedge ACLK);
      hs = IN_READY && IN_VALID;
      tick();
      c++;
      if (hs) begin
        i++;
        if (i < n) IN_DATA = tok_q[i];
      end
    end
    IN_VALID = 1'b0;
    chk("feed_timeout", (i < n), 0);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || BUSY) && c < budget) begin
      tick();
      c++;
    end
    chk("idle_timeout", (c >= budget), 0);
    repeat (3) tick();
  endtask

  int dc, cc;

  initial begin
    ARESET = 1'b1; CFG_VALID = 1'b0; CFG_START_ADDR = '0; CFG_NBYTES = '0;
    WR_CONFIG_READY = 1'b1; IN_DATA = '0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    chk("rst_cfg_ready", CFG_READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_data", OUT_DATA, 0);
    chk("rst_wr_valid", WR_CONFIG_VALID, 0);
    chk("rst_done", DONE, 0);
    chk("rst_in_ready", IN_READY, 0);
    checking = 1'b1;
    tick();

    // one full burst, streaming
    tok_q.delete();
    for (int i = 0; i < 64; i++) tok_q.push_back(IN_W'(i));
    build_model(128);
    chk("model_beat0", exp_q[0], 64'h0003000200010000);
    chk("model_beat15", exp_q[15], 64'h003F003E003D003C);
    obs_q.delete(); dc = done_count; cc = cmd_count;
    send_cmd(32'h1000, 32'd128);
    feed(64);
    wait_idle(200);
    chk("t1_beats", obs_q.size(), 16);
    chk("t1_beat0", obs_q[0], 64'h0003000200010000);
    chk("t1_beat15", obs_q[15], 64'h003F003E003D003C);
    chk("t1_cmds", cmd_count - cc, 1);
    chk("t1_dones", done_count - dc, 1);
    chk("t1_nbytes", last_cmd_nbytes, 128);

    // short payload, zero padding
    tok_q.delete();
    tok_q.push_back(16'hAAAA); tok_q.push_back(16'hBBBB); tok_q.push_back(16'hCCCC);
    build_model(6);
    obs_q.delete(); dc = done_count;
    send_cmd(32'h2000, 32'd6);
    feed(3);
    chk("t2_in_ready_after", IN_READY, 0);
    wait_idle(200);
    chk("t2_nbytes", last_cmd_nbytes, 128);
    chk("t2_beats", obs_q.size(), 16);
    chk("t2_beat0", obs_q[0], 64'h0000CCCCBBBBAAAA);
    chk("t2_beat1", obs_q[1], 64'h0);
    chk("t2_dones", done_count - dc, 1);

    // empty command
    dc = done_count; cc = cmd_count;
    send_cmd(32'h3000, 32'd0);
    chk("t3_done", DONE, 1);
    chk("t3_busy", BUSY, 0);
    chk("t3_cfg_ready", CFG_READY, 1);
    repeat (3) begin
      tick();
      chk("t3_busy_hold", BUSY, 0);
      chk("t3_wr_valid", WR_CONFIG_VALID, 0);
      chk("t3_cfg_ready_hold", CFG_READY, 1);
    end
    chk("t3_dones", done_count - dc, 1);
    chk("t3_cmds", cmd_count - cc, 0);

    // output stall mid-stream
    tok_q.delete();
    for (int i = 0; i < 128; i++) tok_q.push_back(IN_W'(i) ^ 16'h5A5A);
    build_model(256);
    obs_q.delete();
    send_cmd(32'h4000, 32'd256);
    fork
      feed(128);
      begin
        repeat (30) tick();
        OUT_READY = 1'b0;
        repeat (10) tick();
        OUT_READY = 1'b1;
      end
    join
    wait_idle(300);
    chk("t4_beats", obs_q.size(), 32);

    // writer command backpressure
    tok_q.delete();
    for (int i = 0; i < 64; i++) tok_q.push_back(16'hA000 + IN_W'(i));
    build_model(128);
    obs_q.delete();
    WR_CONFIG_READY = 1'b0;
    send_cmd(32'h5000, 32'd128);
    repeat (5) begin
      chk("t5_wr_valid_hold", WR_CONFIG_VALID, 1);
      chk("t5_addr_hold", WR_CONFIG_START_ADDR, 32'h5000);
      chk("t5_in_ready", IN_READY, 0);
      tick();
    end
    WR_CONFIG_READY = 1'b1;
    feed(64);
    wait_idle(200);
    chk("t5_beats", obs_q.size(), 16);
    chk("t5_beat0", obs_q[0], 64'hA003A002A001A000);

    // reset mid-operation, then a fresh command
    tok_q.delete();
    for (int i = 0; i < 64; i++) tok_q.push_back(IN_W'(i * 3));
    build_model(128);
    send_cmd(32'h6000, 32'd128);
    feed(20);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    dc = done_count;
    chk("t6_out_valid", OUT_VALID, 0);
    chk("t6_wr_valid", WR_CONFIG_VALID, 0);
    chk("t6_busy", BUSY, 0);
    chk("t6_done", DONE, 0);
    repeat (3) tick();
    chk("t6_no_done", done_count - dc, 0);
    obs_q.delete();
    build_model(128);
    send_cmd(32'h6000, 32'd128);
    feed(64);
    wait_idle(200);
    chk("t6_beats", obs_q.size(), 16);
    chk("t6_beat0", obs_q[0], 64'h0009000600030000);
    chk("t6_dones", done_count - dc, 1);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
